// File: rtl/ultrascan_ste_pkg.sv
// Shared types and the symbol comparator rule for literal STE chains.
// Latency: n/a (package). Backpressure: n/a.
// Case folding only applies when the pattern byte is a letter; everything else compares exactly.
package ultrascan_ste_pkg;

  localparam int SYMBOL_W = 8;

  typedef enum logic [1:0] {
    START_NONE      = 2'd0,
    START_OF_DATA   = 2'd1,
    START_ALL_INPUT = 2'd2
  } start_type_e;

  function automatic logic fold_eq(input logic [SYMBOL_W-1:0] sym,
                                   input logic [SYMBOL_W-1:0] pat,
                                   input logic                fold);
    logic [SYMBOL_W-1:0] pat_lc;
    pat_lc = pat | 8'h20;
    if (fold && (pat_lc >= 8'h61) && (pat_lc <= 8'h7a)) begin
      return (sym | 8'h20) == pat_lc;
    end
    return sym == pat;
  endfunction

endpackage

// File: rtl/lit_ste_match.sv
// One chain element's symbol comparator against a fixed pattern byte.
// Latency: combinational. Backpressure: none.
// Registration of the hit happens in the chain owner.
module lit_ste_match
  import ultrascan_ste_pkg::*;
#(
  parameter logic [SYMBOL_W-1:0] PAT_BYTE  = 8'h61,
  parameter bit                  CASE_FOLD = 1'b1
) (
  input  logic [SYMBOL_W-1:0] symbol,
  output logic                hit
);

  assign hit = fold_eq(symbol, PAT_BYTE, CASE_FOLD);

endmodule

// File: rtl/literal_chain_automaton.sv
// Literal-string STE chain with optional case folding and saturating report count.
// Latency: report one cycle after the completing symbol. Backpressure: run strobe gates consumption;
// offset records (REPORT_OFFSET_EN) use valid/ready and drop with a sticky overflow when held full.
module literal_chain_automaton
  import ultrascan_ste_pkg::*;
#(
  parameter int                LEN        = 11,
  parameter logic [8*LEN-1:0]  PATTERN    = "execcommand",
  parameter bit                CASE_FOLD  = 1'b1,
  parameter int                START_TYPE = 2,
  parameter int                COUNT_W    = 16,
  parameter int                OFFSET_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [SYMBOL_W-1:0] symbols,
  output logic                report,
  output logic [COUNT_W-1:0]  report_count
`ifdef REPORT_OFFSET_EN
  ,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [OFFSET_W-1:0] rpt_offset,
  output logic                rpt_overflow
`endif
);

  if (LEN < 1 || COUNT_W < 1 || OFFSET_W < 1) begin : g_bad_param
    $error("literal_chain_automaton: LEN, COUNT_W and OFFSET_W must be >= 1");
  end

  logic [LEN-1:0] active;
  logic [LEN-1:0] hit;
  logic [LEN-1:0] en;
  logic           first;
  logic           start_en;
  logic           done;

  for (genvar g = 0; g < LEN; g++) begin : g_ste
    lit_ste_match #(
      .PAT_BYTE  (PATTERN[8*(LEN-1-g) +: 8]),
      .CASE_FOLD (CASE_FOLD)
    ) u_match (
      .symbol (symbols),
      .hit    (hit[g])
    );
  end

  assign start_en = (START_TYPE == int'(START_ALL_INPUT)) ||
                    ((START_TYPE == int'(START_OF_DATA)) && first);

  if (LEN > 1) begin : g_chain
    assign en = {active[LEN-2:0], start_en};
  end else begin : g_single
    assign en = start_en;
  end

  assign done   = run & en[LEN-1] & hit[LEN-1];
  assign report = active[LEN-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active       <= '0;
      first        <= 1'b1;
      report_count <= '0;
    end else if (run) begin
      active <= en & hit;
      first  <= 1'b0;
      if (done && (report_count != {COUNT_W{1'b1}})) begin
        report_count <= report_count + COUNT_W'(1);
      end
    end
  end

`ifdef REPORT_OFFSET_EN
  logic [OFFSET_W-1:0] offset;

  // offset tags the symbol being consumed this cycle, so the record takes the pre-increment value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset       <= '0;
      rpt_valid    <= 1'b0;
      rpt_offset   <= '0;
      rpt_overflow <= 1'b0;
    end else begin
      if (run) begin
        offset <= offset + OFFSET_W'(1);
      end
      if (done) begin
        if (!rpt_valid || rpt_ready) begin
          rpt_valid  <= 1'b1;
          rpt_offset <= offset;
        end else begin
          rpt_overflow <= 1'b1;
        end
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end
    end
  end
`endif

endmodule
